// File: rtl/csm51a_window_fn.sv
// csm51a_window_fn
//   Sliding-window Boolean function evaluator. Serial bits shift into a
//   WIDTH-bit window that indexes a 2^WIDTH-entry truth table. The table can
//   be reloaded serially at run time and swaps in atomically. A saturating
//   counter tracks how many evaluations returned 1. The reset table computes
//   z = x2'x1'x0 + x1x0' (x0 newest).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   x_in         serial data bit, accepted when x_valid=1
//   x_valid      accept strobe (no backpressure)
//   tt_start     one-cycle pulse that begins or restarts a table load
//   tt_bit       table bit, entry TT_N-1 first down to entry 0
//   tt_bit_valid qualifies tt_bit, honoured only while loading
//   cnt_clr      clears match_count (wins over a coincident increment)
//   z            registered evaluation result
//   z_valid      one-cycle pulse marking a new z once the window is full
//   loading      high while a table load is in progress
//   match_count  saturating count of z_valid cycles with z=1
//   window       current window, window[0] is the newest bit
module csm51a_window_fn #(
  parameter int unsigned               WIDTH      = 3,
  parameter logic [(2**WIDTH)-1:0]     DEFAULT_TT = 8'h46,
  parameter int unsigned               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_in,
  input  logic             x_valid,
  input  logic             tt_start,
  input  logic             tt_bit,
  input  logic             tt_bit_valid,
  input  logic             cnt_clr,
  output logic             z,
  output logic             z_valid,
  output logic             loading,
  output logic [CNT_W-1:0] match_count,
  output logic [WIDTH-1:0] window
);

  localparam int unsigned TT_N   = 2**WIDTH;
  localparam int unsigned FILL_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state;
  logic [TT_N-1:0]   active_tt;
  logic [TT_N-1:0]   shadow;
  logic [WIDTH-1:0]  bit_cnt;
  logic [FILL_W-1:0] fill;

  logic [WIDTH-1:0]  window_next;
  logic              z_next;
  logic              full_next;
  logic [TT_N-1:0]   shadow_merged;

  always_comb begin
    window_next   = {window[WIDTH-2:0], x_in};
    z_next        = active_tt[window_next];
    // The window is full after this accept if WIDTH-1 or more were already in.
    full_next     = (fill >= FILL_W'(WIDTH - 1));
    // Final bit (entry 0) is merged directly so the commit needs no extra cycle.
    shadow_merged = {shadow[TT_N-1:1], tt_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window      <= '0;
      fill        <= '0;
      z           <= 1'b0;
      z_valid     <= 1'b0;
      match_count <= '0;
      loading     <= 1'b0;
      state       <= IDLE;
      active_tt   <= DEFAULT_TT;
      shadow      <= '0;
      bit_cnt     <= '0;
    end else begin
      z_valid <= 1'b0;

      if (x_valid) begin
        window  <= window_next;
        z       <= z_next;
        z_valid <= full_next;
        if (fill != FILL_W'(WIDTH)) begin
          fill <= fill + 1'b1;
        end
      end

      if (cnt_clr) begin
        match_count <= '0;
      end else if (x_valid && full_next && z_next && (match_count != '1)) begin
        match_count <= match_count + 1'b1;
      end

      // active_tt is only written here with a non-blocking assignment, so an
      // accept on the commit edge still evaluates against the old table.
      case (state)
        IDLE: begin
          if (tt_start) begin
            state   <= LOAD;
            loading <= 1'b1;
            bit_cnt <= '1;
            shadow  <= '0;
          end
        end
        LOAD: begin
          if (tt_start) begin
            bit_cnt <= '1;
            shadow  <= '0;
          end else if (tt_bit_valid) begin
            shadow[bit_cnt] <= tt_bit;
            if (bit_cnt == '0) begin
              active_tt <= shadow_merged;
              state     <= IDLE;
              loading   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          loading <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csm51a_window_fn.sv
module tb_csm51a_window_fn;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x_in = 1'b0;
  logic       x_valid = 1'b0;
  logic       tt_start = 1'b0;
  logic       tt_bit = 1'b0;
  logic       tt_bit_valid = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       z;
  logic       z_valid;
  logic       loading;
  logic [1:0] match_count;
  logic [2:0] window;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic       ev;
    logic       ez;
    logic [2:0] ew;
    logic [1:0] ec;
  } exp_t;

  exp_t q[$];

  // Reference state kept by the stimulus side
  logic [2:0] wm = '0;
  int         fm = 0;
  logic [1:0] cm = '0;

  csm51a_window_fn #(
    .WIDTH(3),
    .DEFAULT_TT(8'h46),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .x_in(x_in),
    .x_valid(x_valid),
    .tt_start(tt_start),
    .tt_bit(tt_bit),
    .tt_bit_valid(tt_bit_valid),
    .cnt_clr(cnt_clr),
    .z(z),
    .z_valid(z_valid),
    .loading(loading),
    .match_count(match_count),
    .window(window)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs set at negedge, returns 1 time unit after the edge
  // with all inputs idle again.
  task automatic drive(input bit r, input bit xv, input bit x, input bit st,
                       input bit bv, input bit b, input bit clr, input bit ez);
    exp_t e;
    @(negedge clk);
    rst = r; x_valid = xv; x_in = x; tt_start = st;
    tt_bit_valid = bv; tt_bit = b; cnt_clr = clr;
    if (r) begin
      wm = '0; fm = 0; cm = '0;
    end else begin
      if (xv) begin
        wm = {wm[1:0], x};
        if (fm < 3) fm++;
        e.ev = (fm == 3);
        e.ez = ez;
        e.ew = wm;
      end
      if (clr) cm = '0;
      else if (xv && (fm == 3) && ez && cm != 2'd3) cm = cm + 2'd1;
      if (xv) begin
        e.ec = cm;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; x_valid = 1'b0; x_in = 1'b0; tt_start = 1'b0;
    tt_bit_valid = 1'b0; tt_bit = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic acc(input bit x, input bit ez);
    drive(0, 1, x, 0, 0, 0, 0, ez);
  endtask

  task automatic tbit(input bit b);
    drive(0, 0, 0, 0, 1, b, 0, 0);
  endtask

  // Monitor: pops one expectation per accept edge and compares outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("z_valid", {7'd0, z_valid}, {7'd0, e.ev});
        chk("window", {5'd0, window}, {5'd0, e.ew});
        chk("match_count", {6'd0, match_count}, {6'd0, e.ec});
        if (e.ev) chk("z", {7'd0, z}, {7'd0, e.ez});
      end else begin
        chk("idle_z_valid", {7'd0, z_valid}, 8'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_z", {7'd0, z}, 8'd0);
    chk("rst_z_valid", {7'd0, z_valid}, 8'd0);
    chk("rst_loading", {7'd0, loading}, 8'd0);
    chk("rst_count", {6'd0, match_count}, 8'd0);
    chk("rst_window", {5'd0, window}, 8'd0);

    // Default function, fill then stream
    acc(0, 0); acc(0, 0); acc(1, 1);
    acc(0, 1); acc(0, 0); acc(1, 1);
    chk("count_after_stream", {6'd0, match_count}, 8'd3);

    // Load 8'h80 with gaps while streaming 1s; old table on the commit edge
    pat = 8'h80;
    drive(0, 1, 1, 1, 0, 0, 1, 0);
    chk("load_rise", {7'd0, loading}, 8'd1);
    for (int k = 7; k >= 0; k--) begin
      drive(0, 1, 1, 0, 1, pat[k], 0, 0);
      chk("load_span", {7'd0, loading}, (k != 0) ? 8'd1 : 8'd0);
      if (k != 0) begin
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        chk("load_gap", {7'd0, loading}, 8'd1);
      end
    end
    acc(1, 1);

    // Restart after 4 bits, then load 8'h01
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) tbit(1);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    chk("restart_loading", {7'd0, loading}, 8'd1);
    pat = 8'h01;
    for (int k = 7; k >= 0; k--) tbit(pat[k]);
    chk("restart_done", {7'd0, loading}, 8'd0);
    acc(0, 0); acc(0, 0); acc(0, 1); acc(1, 0); acc(1, 0); acc(1, 0);

    // tt_start with the final bit: restart wins, no commit
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) tbit(1);
    drive(0, 0, 0, 1, 1, 1, 0, 0);
    chk("start_vs_final", {7'd0, loading}, 8'd1);
    acc(0, 0);
    for (int k = 0; k < 3; k++) tbit(1);

    // Reset mid-load
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_loading", {7'd0, loading}, 8'd0);
    chk("midrst_window", {5'd0, window}, 8'd0);
    chk("midrst_count", {6'd0, match_count}, 8'd0);
    chk("midrst_z", {7'd0, z}, 8'd0);
    acc(0, 0); acc(1, 0); acc(0, 1); acc(0, 0); acc(1, 1);

    // Saturation and clear with table 8'hFF
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) tbit(1);
    chk("ff_loaded", {7'd0, loading}, 8'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("clr_idle", {6'd0, match_count}, 8'd0);
    for (int k = 0; k < 5; k++) acc(k[0], 1);
    chk("saturated", {6'd0, match_count}, 8'd3);
    drive(0, 1, 1, 0, 0, 0, 1, 1);
    chk("clr_wins", {6'd0, match_count}, 8'd0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    if (q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
